// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift arbiter: direction, request bundle, slot state.
// The rot field exists only when SHIFT_ARB_ROTATE_EN is defined.
package shift_arb_pkg;

    localparam int SHIFT_W = 8;

    typedef enum logic {
        SHL = 1'b0,
        SHR = 1'b1
    } shift_dir_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [SHIFT_W-1:0] operand;
        logic [SHIFT_W-1:0] amount;
        shift_dir_e         dir;
`ifdef SHIFT_ARB_ROTATE_EN
        logic               rot;
`endif
    } shift_req_t;

endpackage

// File: rtl/shift_arbiter_rr.sv
// Round-robin arbiter: first valid requester at or after ptr, wrapping mod N.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    function automatic logic [IW-1:0] wrap(logic [IW-1:0] p, int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !gnt_vld && req[wrap(ptr, k)]) begin
                gnt_vld              = 1'b1;
                gnt_idx              = wrap(ptr, k);
                gnt[wrap(ptr, k)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared 8-bit shifter with one registered, id-tagged response slot.
// Define SHIFT_ARB_ROTATE_EN to add req_rot (per-requester rotate select).
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_operand,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_amount,
    input  logic [NUM_REQ-1:0]         req_dir,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic [NUM_REQ-1:0]         req_rot,
`endif
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic [ID_W-1:0]            rsp_id
);

    if (DATA_W != SHIFT_W) begin : g_bad_data_w
        $error("shift_arbiter: DATA_W must be 8");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("shift_arbiter: NUM_REQ must be 2..8");
    end

    slot_state_e                 state, state_nxt;
    shift_req_t [NUM_REQ-1:0]    reqs;
    shift_req_t                  sel;
    logic [ID_W-1:0]             ptr;
    logic [ID_W-1:0]             gnt_idx;
    logic                        gnt_vld;
    logic                        free;
    logic                        accept;

    function automatic logic [SHIFT_W-1:0] shift_op(shift_req_t r);
        logic [2:0] sh;
`ifdef SHIFT_ARB_ROTATE_EN
        logic [2*SHIFT_W-1:0] rl, rr;
`endif
        sh = r.amount[2:0];
`ifdef SHIFT_ARB_ROTATE_EN
        // Rotate via a doubled operand so wrap-around bits fall out naturally.
        if (r.rot) begin
            rl = {r.operand, r.operand} << sh;
            rr = {r.operand, r.operand} >> sh;
            return (r.dir == SHL) ? rl[2*SHIFT_W-1:SHIFT_W] : rr[SHIFT_W-1:0];
        end
`endif
        if (r.amount >= 8'(SHIFT_W)) return '0;
        return (r.dir == SHL) ? (r.operand << sh) : (r.operand >> sh);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].operand = req_operand[SHIFT_W*i +: SHIFT_W];
            reqs[i].amount  = req_amount[SHIFT_W*i +: SHIFT_W];
            reqs[i].dir     = shift_dir_e'(req_dir[i]);
`ifdef SHIFT_ARB_ROTATE_EN
            reqs[i].rot     = req_rot[i];
`endif
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    assign free = (state == EMPTY) || rsp_ready;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (free && rst_n),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // A grant is only ever issued to a valid requester, so grant == accept.
    assign accept    = gnt_vld;
    assign sel       = reqs[gnt_idx];
    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_id     <= '0;
            ptr        <= '0;
        end else if (accept) begin
            rsp_result <= shift_op(sel);
            rsp_id     <= gnt_idx;
            ptr        <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed literal cases plus randomized traffic
// compared every cycle against a queue-free behavioural model.
module tb_shift_arbiter;

    localparam int NR = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid, req_ready, req_dir;
    logic [NR*8-1:0] req_operand, req_amount;
`ifdef SHIFT_ARB_ROTATE_EN
    logic [NR-1:0]   req_rot;
`endif
    logic            rsp_valid, rsp_ready;
    logic [7:0]      rsp_result;
    logic [IW-1:0]   rsp_id;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    bit m_vld    = 1'b0;
    int m_res    = 0;
    int m_id     = 0;
    int m_ptr    = 0;
    int acc_last = -1;

    always #5 clk = ~clk;

    shift_arbiter #(.NUM_REQ(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_operand (req_operand),
        .req_amount  (req_amount),
        .req_dir     (req_dir),
`ifdef SHIFT_ARB_ROTATE_EN
        .req_rot     (req_rot),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_id      (rsp_id)
    );

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_shift(int op, int amt, bit dir, bit rot);
        if (rot) begin
            int a = amt % 8;
            if (!dir) return ((op << a) | (op >> (8 - a))) & 255;
            return ((op >> a) | (op << (8 - a))) & 255;
        end
        if (amt >= 8) return 0;
        return dir ? (op >> amt) : ((op << amt) & 255);
    endfunction

    function automatic bit rot_of(int i);
`ifdef SHIFT_ARB_ROTATE_EN
        return req_rot[i];
`else
        return (i < 0);
`endif
    endfunction

    function automatic int lane_result(int g);
        return ref_shift(int'(req_operand[g*8 +: 8]), int'(req_amount[g*8 +: 8]),
                         req_dir[g], rot_of(g));
    endfunction

    // Winner this cycle, or -1 when nothing can be accepted.
    function automatic int grant_of();
        if (!rst_n) return -1;
        if (m_vld && !rsp_ready) return -1;
        for (int k = 0; k < NR; k++)
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r = '0;
        int g = grant_of();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld    <= 1'b0;
            m_res    <= 0;
            m_id     <= 0;
            m_ptr    <= 0;
            acc_last <= -1;
        end else begin
            acc_last <= grant_of();
            if (grant_of() >= 0) begin
                m_vld <= 1'b1;
                m_res <= lane_result(grant_of());
                m_id  <= grant_of();
                m_ptr <= (grant_of() + 1) % NR;
            end else if (rsp_ready) begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  int'(req_ready),  int'(exp_ready()));
            check("rsp_valid",  int'(rsp_valid),  int'(m_vld));
            check("rsp_result", int'(rsp_result), m_res);
            check("rsp_id",     int'(rsp_id),     m_id);
        end
    end

    task automatic set_lane(int i, int op, int amt, bit dir, bit rot);
        req_operand[i*8 +: 8] = 8'(op);
        req_amount[i*8 +: 8]  = 8'(amt);
        req_dir[i]            = dir;
`ifdef SHIFT_ARB_ROTATE_EN
        req_rot[i]            = rot;
`else
        if (rot) $display("note: rotate request ignored without rotate build");
`endif
    endtask

    // Lone request on lane 0 with the slot draining; result due one cycle later.
    task automatic drive_one(string name, int op, int amt, bit dir, bit rot, int expv);
        set_lane(0, op, amt, dir, rot);
        req_valid = 3'b001;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        check({name, "_valid"}, int'(rsp_valid), 1);
        check(name, int'(rsp_result), expv);
        check({name, "_id"}, int'(rsp_id), 0);
        check({name, "_model"}, m_res, expv);
    endtask

    initial begin
        req_valid = '0; req_dir = '0; req_operand = '0; req_amount = '0; rsp_ready = 1'b1;
`ifdef SHIFT_ARB_ROTATE_EN
        req_rot = '0;
`endif
        rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_ready",  int'(req_ready),  0);
        check("rst_valid",  int'(rsp_valid),  0);
        check("rst_result", int'(rsp_result), 0);
        check("rst_id",     int'(rsp_id),     0);
        req_valid = '0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        drive_one("single",   8'h81, 1,   1'b0, 1'b0, 8'h02);
        drive_one("shr_8",    8'hF0, 8,   1'b1, 1'b0, 8'h00);
        drive_one("shl_255",  8'hF0, 255, 1'b0, 1'b0, 8'h00);
        drive_one("shr_0",    8'hA5, 0,   1'b1, 1'b0, 8'hA5);
        drive_one("shr_7",    8'h80, 7,   1'b1, 1'b0, 8'h01);
`ifdef SHIFT_ARB_ROTATE_EN
        drive_one("rotl_1",   8'h81, 1,   1'b0, 1'b1, 8'h03);
        drive_one("rotr_9",   8'h81, 9,   1'b1, 1'b1, 8'hC0);
        drive_one("rotl_16",  8'h5A, 16,  1'b0, 1'b1, 8'h5A);
`endif

        // Contention: last winner was lane 0, so lane 1 leads and they alternate.
        set_lane(0, 8'h11, 1, 1'b0, 1'b0);
        set_lane(1, 8'h22, 1, 1'b1, 1'b0);
        req_valid = 3'b011;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("fair_id", int'(rsp_id), (c % 2 == 0) ? 1 : 0);
        end

        // Backpressure: fill the slot, hold it three cycles, then refill with no bubble.
        req_valid = '0;
        @(posedge clk); #1;
        set_lane(0, 8'h0F, 4, 1'b0, 1'b0);
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_fill", int'(rsp_result), 8'hF0);
        set_lane(1, 8'h3C, 2, 1'b1, 1'b0);
        req_valid = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready", int'(req_ready), 0);
            check("bp_hold",  int'(rsp_result), 8'hF0);
            check("bp_id",    int'(rsp_id), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(req_ready), 3'b010);
        @(posedge clk); #1;
        check("bp_nobubble", int'(rsp_valid), 1);
        check("bp_new",      int'(rsp_result), 8'h0F);
        check("bp_new_id",   int'(rsp_id), 1);

        // Leave lane 0 as last winner (ptr=1), slot full, then reset mid-flight.
        set_lane(0, 8'h01, 3, 1'b0, 1'b0);
        req_valid = 3'b001;
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid",  int'(rsp_valid), 0);
        check("rst_async_result", int'(rsp_result), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b011;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_first_winner", int'(rsp_id), 0);

        // Randomized traffic; requests are held until accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc_last == i) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    set_lane(i, int'(8'($urandom)),
                             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                         : int'($urandom_range(0, 9)),
                             1'($urandom),
`ifdef SHIFT_ARB_ROTATE_EN
                             1'($urandom));
`else
                             1'b0);
`endif
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk); #1;
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 8-bit shift unit between NUM_REQ requesters (e.g. ALU issue and load/store byte-lane alignment) using round-robin arbitration.
- Each requester presents a valid/ready handshake. The result, tagged with the requester id, goes into a single registered response slot with its own valid/ready handshake.
- Sits between the issue stage and the writeback mux; it is the only path by which requesters reach the shift unit.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, operand/result width. Fixed at 8; any other value is a compile-time error.
- ID_W, $clog2(NUM_REQ) with minimum 1, response id width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_operand  in  NUM_REQ*8  packed operands; requester i occupies bits [8i+7:8i].
- req_amount  in  NUM_REQ*8  packed shift amounts, unsigned.
- req_dir  in  NUM_REQ  0 = left shift, 1 = logical right shift.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  8  shifted value.
- rsp_id  out  ID_W  index of the requester that produced rsp_result.

Behaviour:
- Reset (async assert, sync deassert at consumer): rsp_valid=0, rsp_result=0, rsp_id=0, rr pointer=0, state=EMPTY. req_ready is combinational and therefore 0 while in reset.
- Slot free condition: free = !rsp_valid || rsp_ready.
- Grant: when free, grant goes to the first requester with valid set, searching i = ptr, ptr+1, ... mod NUM_REQ. req_ready[g]=1 only for that winner; all others are 0. req_ready never depends on the winner's own req_valid except through the search.
- Accept: occurs when req_valid[g] && req_ready[g]. On that cycle's clock edge:
  - the slot loads result, id=g, and rsp_valid=1;
  - ptr becomes (g+1) mod NUM_REQ.
- Pointer hold: ptr is unchanged when nothing is accepted.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 result per cycle while rsp_ready is held high.
- State machine (two states):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no new accept.
  - FULL -> FULL on rsp_ready with a simultaneous accept; the slot is overwritten by the new result with no bubble.
  - FULL with rsp_ready=0: holds; rsp_result and rsp_id stay stable; all req_ready=0.
- Arithmetic:
  - amount >= 8 gives result 0 in both directions; the full 8-bit amount is compared, with no truncation to 3 bits.
  - Right shift is logical (zero fill).
  - amount 0 passes the operand through unchanged.
- No requests valid: no grant, ptr unchanged, and the slot drains normally.
- Reset mid-operation: any held response is discarded without handshake; the consumer must tolerate losing it.
- Requester obligations: requesters must hold operand, amount, and dir stable while valid and not yet accepted. The block does not check this.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined:
  - adds input req_rot (NUM_REQ bits);
  - req_rot[i]=1 selects rotate in direction req_dir[i], by amount mod 8;
  - rotate by a multiple of 8 returns the operand unchanged;
  - req_rot is captured at accept alongside the other request fields.
- Undefined: the port is absent and only logical shifts are performed.

Decomposition:
- Package shift_arb_pkg holds:
  - the typedef for shift direction (SHL=0, SHR=1);
  - a localparam for shift width 8;
  - a shift_req_t struct {operand, amount, dir[, rot]}.
- Sub-module rr_arbiter (parameter N) is natural: it takes the request vector, pointer, and enable, and outputs a one-hot grant plus grant index.
- The shift function stays in shift_arbiter as a combinational function.

Test Plan:
- Single request, contention-free: req0 = {0x81, 1, left}, rsp_ready=1 -> next cycle rsp_valid=1, result 0x02, id 0.
- Contention and fairness: req0 and req1 both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; no requester is granted twice in a row while the other is waiting.
- Backpressure: response FULL with rsp_ready=0 for 3 cycles -> req_ready=0 throughout; result/id held; on rsp_ready=1 a same-cycle accept replaces the slot with no bubble cycle.
- Boundary amounts: {0xF0, 8, right} -> 0x00; {0xF0, 255, left} -> 0x00; {0xA5, 0, right} -> 0xA5; {0x80, 7, right} -> 0x01.
- Reset mid-operation: assert rst_n=0 while FULL -> rsp_valid drops immediately (async); after release, ptr=0 so req0 wins the first contention.
- With SHIFT_ARB_ROTATE_EN: {0x81, 1, left, rot} -> 0x03; {0x81, 9, right, rot} -> 0xC0.
